rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-back arbiter for the integer register file's single write port. It accepts completed results from two producers, the ALU (requester 0) and the load/store unit (requester 1), over valid/ready handshakes. Each cycle it grants at most one request and drives the register file's `rd_in`, `data_write` and `write_en` from a registered output stage. It sits between the execute/memory stages and the register file and also counts write-port conflicts for performance analysis.

## Interface
Parameters:
- `REG_DATA_WIDTH_POW`, default 6: data width is `1 << REG_DATA_WIDTH_POW`, so 64 bits by default.
- `REG_MEM_DEPTH_POW`, default 5: register index width; 32 registers by default.
- `CNT_WIDTH`, default 16: width of the conflict counter.

Ports:
- `clk_in`, in, 1: single clock; all state updates on the rising edge.
- `rst_n_in`, in, 1: asynchronous, active-low reset.
- `req_valid_in`, in, 2: per-requester valid; bit 0 is the ALU, bit 1 is the LSU.
- `req_rd_in`, in, 2×`REG_MEM_DEPTH_POW`: destination register per requester.
- `req_data_in`, in, 2×data width: result data per requester.
- `req_ready_out`, out, 2: per-requester accept, combinational.
- `wb_write_en_out`, out, 1: drives the register file `write_en`.
- `wb_rd_out`, out, `REG_MEM_DEPTH_POW`: drives the register file `rd_in`.
- `wb_data_out`, out, data width: drives the register file `data_write`.
- `conflict_cnt_out`, out, `CNT_WIDTH`: saturating count of cycles in which both requests are valid, both have rd≠0, and one is stalled.

## Operation
- **Handshake:** a transfer occurs on requester i when `req_valid_in[i] && req_ready_out[i]` at a rising edge.
  - Once valid is raised, valid, rd and data must stay stable until the transfer.
  - A requester may not drop valid before it is accepted.
- **Zero-register requests:** a request with rd = 0 is a sink.
  - `req_ready_out[i] = 1` whenever it is valid, independent of the other requester.
  - It never produces `wb_write_en_out`.
- **Arbitration:** applies only among valid requests with rd ≠ 0.
  - One candidate: it gets ready.
  - Two candidates: exactly one gets ready, selected by the arbitration policy (see Configuration). The loser sees ready = 0 and holds.
- **Output stage:** on a grant of a request with rd ≠ 0, at the next edge:
  - `wb_write_en_out` ← 1;
  - `wb_rd_out` ← the granted rd;
  - `wb_data_out` ← the granted data.
  
  With no grant, `wb_write_en_out` ← 0 and `wb_rd_out`/`wb_data_out` hold their previous values.
- **Conflict counter:** increments by 1 in every cycle with two rd≠0 candidates. It saturates at all-ones; it does not wrap.
- **Round-robin pointer** (macro enabled): a 1-bit `last_grant` register that updates only when a two-candidate conflict is resolved. It then records the winner, and the next conflict favours the other requester. Single-candidate grants do not change it.

## Timing
- **Reset** (`rst_n_in` = 0, asynchronous, effective immediately):
  - `wb_write_en_out` = 0, `wb_rd_out` = 0, `wb_data_out` = 0;
  - `conflict_cnt_out` = 0;
  - `last_grant` = 1, so the first conflict after reset is won by the ALU.
  - `req_ready_out` is forced to 2'b00 while reset is asserted.
- **Reset mid-operation:** any grant in flight is discarded. No write is issued after reset is released unless a new handshake occurs.
- **Latency:** a handshake at edge E asserts the write signals during cycle E→E+1. The register file captures the write at edge E+1.
- **Throughput:** one register write per cycle; back-to-back grants are allowed.
- **`req_ready_out` path:** purely combinational from `req_valid_in`, `req_rd_in`, `last_grant` and reset. There is no valid-to-valid loop.

## Configuration
The arbitration policy is selected by the `RF_WB_ROUND_ROBIN_EN` macro.
- **Defined:** round-robin arbitration using `last_grant`, as described above.
- **Undefined:** fixed priority; the LSU (requester 1) always wins conflicts. The `last_grant` register is not built, and its reset value has no effect.
- The conflict counter and all other behaviour are identical in both builds.

## Test plan
1. **Reset values:** assert reset with both requests valid → ready = 00, write_en = 0, rd = 0, data = 0, counter = 0.
2. **Single ALU request:** rd = 5, data = 0xDEAD_BEEF_0000_0001 → ready[0] = 1 in the same cycle; next cycle write_en = 1, rd = 5, data = 0xDEAD_BEEF_0000_0001; the cycle after, write_en = 0.
3. **Zero-register sink:** LSU rd = 0 together with ALU rd = 3 → both ready = 1; exactly one write, to rd = 3; counter stays 0.
4. **Round-robin build:** both valid with rd = 7 (ALU) and rd = 9 (LSU), held steady → grants ALU, then LSU, on consecutive cycles; write_en held at 1 for 2 cycles; counter = 1.
5. **Fixed-priority build:** same stimulus as scenario 4 → LSU is granted first, then the ALU; counter = 1.
6. **Counter saturation:** with `CNT_WIDTH` = 4, hold a conflict for 20 cycles while the winner keeps re-requesting → counter reaches 15 and stays there; an asynchronous reset mid-burst clears it to 0 with no write issued.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// ============================================================================
// Module   : rf_wb_arbiter
// Purpose  : Two-requester (ALU/LSU) write-back arbiter for the integer
//            register file write port, with a saturating conflict counter.
//            Optional macro RF_WB_ROUND_ROBIN_EN selects round-robin
//            arbitration; otherwise the LSU has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wb_arbiter #(
  parameter int REG_DATA_WIDTH_POW = 6,
  parameter int REG_MEM_DEPTH_POW  = 5,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                                     clk_in,
  input  logic                                     rst_n_in,
  input  logic [1:0]                               req_valid_in,
  input  logic [2*REG_MEM_DEPTH_POW-1:0]           req_rd_in,
  input  logic [2*(1<<REG_DATA_WIDTH_POW)-1:0]     req_data_in,
  output logic [1:0]                               req_ready_out,
  output logic                                     wb_write_en_out,
  output logic [REG_MEM_DEPTH_POW-1:0]             wb_rd_out,
  output logic [(1<<REG_DATA_WIDTH_POW)-1:0]       wb_data_out,
  output logic [CNT_WIDTH-1:0]                     conflict_cnt_out
);

  localparam int DATA_W = 1 << REG_DATA_WIDTH_POW;
  localparam int RD_W   = REG_MEM_DEPTH_POW;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [RD_W-1:0]   rd0, rd1, sel_rd;
  logic [DATA_W-1:0] data0, data1, sel_data;
  logic [1:0]        cand, sink, grant;
  logic              conflict, winner;

  assign rd0   = req_rd_in[RD_W-1:0];
  assign rd1   = req_rd_in[2*RD_W-1:RD_W];
  assign data0 = req_data_in[DATA_W-1:0];
  assign data1 = req_data_in[2*DATA_W-1:DATA_W];

  // Requests to x0 are sinks: accepted immediately, never written.
  assign cand[0] = req_valid_in[0] && (rd0 != '0);
  assign cand[1] = req_valid_in[1] && (rd1 != '0);
  assign sink[0] = req_valid_in[0] && (rd0 == '0);
  assign sink[1] = req_valid_in[1] && (rd1 == '0);
  assign conflict = cand[0] && cand[1];

`ifdef RF_WB_ROUND_ROBIN_EN
  logic last_grant;

  // last_grant = 1 means the LSU won the previous conflict, so the ALU is next.
  assign winner = ~last_grant;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      last_grant <= 1'b1;
    end else if (conflict) begin
      last_grant <= winner;
    end
  end
`else
  assign winner = 1'b1;
`endif

  always_comb begin
    grant = cand;
    if (conflict) begin
      grant = winner ? 2'b10 : 2'b01;
    end
  end

  assign req_ready_out = rst_n_in ? (sink | grant) : 2'b00;
  assign sel_rd        = grant[1] ? rd1   : rd0;
  assign sel_data      = grant[1] ? data1 : data0;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wb_write_en_out <= 1'b0;
      wb_rd_out       <= '0;
      wb_data_out     <= '0;
    end else if (grant != 2'b00) begin
      wb_write_en_out <= 1'b1;
      wb_rd_out       <= sel_rd;
      wb_data_out     <= sel_data;
    end else begin
      wb_write_en_out <= 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      conflict_cnt_out <= '0;
    end else if (conflict && (conflict_cnt_out != CNT_MAX)) begin
      conflict_cnt_out <= conflict_cnt_out + CNT_WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// ============================================================================
// Module   : tb_rf_wb_arbiter
// Purpose  : Directed self-checking bench for rf_wb_arbiter (4-bit counter).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_wb_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   valid = 2'b00;
  logic [9:0]   rd = '0;
  logic [127:0] data = '0;
  logic [1:0]   ready;
  logic         we;
  logic [4:0]   wrd;
  logic [63:0]  wdata;
  logic [3:0]   cnt;

  int total = 0;
  int bad = 0;

  rf_wb_arbiter #(
    .REG_DATA_WIDTH_POW(6),
    .REG_MEM_DEPTH_POW (5),
    .CNT_WIDTH         (4)
  ) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .req_valid_in    (valid),
    .req_rd_in       (rd),
    .req_data_in     (data),
    .req_ready_out   (ready),
    .wb_write_en_out (we),
    .wb_rd_out       (wrd),
    .wb_data_out     (wdata),
    .conflict_cnt_out(cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid = 2'b11;
    rd    = {5'd6, 5'd4};
    data  = {64'hAAAA, 64'h5555};
    #3;
    total++; if (ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b want=00", ready); end
    total++; if (we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", we); end
    total++; if (wrd !== 5'd0) begin bad++; $display("FAIL reset_rd got=%0d want=0", wrd); end
    total++; if (wdata !== 64'd0) begin bad++; $display("FAIL reset_data got=%h want=0", wdata); end
    total++; if (cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", cnt); end
    step();
    total++; if (we !== 1'b0) begin bad++; $display("FAIL reset_edge_we got=%b want=0", we); end
    valid = 2'b00;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_alu();
    valid = 2'b01;
    rd    = {5'd0, 5'd5};
    data  = {64'd0, 64'hDEAD_BEEF_0000_0001};
    #1;
    total++; if (ready !== 2'b01) begin bad++; $display("FAIL alu_ready got=%b want=01", ready); end
    step();
    valid = 2'b00;
    total++; if (we !== 1'b1) begin bad++; $display("FAIL alu_we got=%b want=1", we); end
    total++; if (wrd !== 5'd5) begin bad++; $display("FAIL alu_rd got=%0d want=5", wrd); end
    total++; if (wdata !== 64'hDEAD_BEEF_0000_0001) begin bad++; $display("FAIL alu_data got=%h want=deadbeef00000001", wdata); end
    step();
    total++; if (we !== 1'b0) begin bad++; $display("FAIL alu_we_drop got=%b want=0", we); end
    total++; if (wrd !== 5'd5) begin bad++; $display("FAIL alu_rd_hold got=%0d want=5", wrd); end
  endtask

  task automatic test_zero_sink();
    valid = 2'b11;
    rd    = {5'd0, 5'd3};
    data  = {64'h0BAD, 64'h3333};
    #1;
    total++; if (ready !== 2'b11) begin bad++; $display("FAIL sink_ready got=%b want=11", ready); end
    step();
    valid = 2'b00;
    total++; if (we !== 1'b1) begin bad++; $display("FAIL sink_we got=%b want=1", we); end
    total++; if (wrd !== 5'd3) begin bad++; $display("FAIL sink_rd got=%0d want=3", wrd); end
    total++; if (wdata !== 64'h3333) begin bad++; $display("FAIL sink_data got=%h want=3333", wdata); end
    step();
    total++; if (we !== 1'b0) begin bad++; $display("FAIL sink_single_write got=%b want=0", we); end
    total++; if (cnt !== 4'd0) begin bad++; $display("FAIL sink_cnt got=%0d want=0", cnt); end
  endtask

  task automatic test_conflict();
    logic [1:0]  first_ready, second_ready;
    logic [4:0]  first_rd, second_rd;
    logic [63:0] first_data, second_data;
`ifdef RF_WB_ROUND_ROBIN_EN
    first_ready = 2'b01; first_rd = 5'd7; first_data = 64'h1111_2222_3333_4444;
    second_ready = 2'b10; second_rd = 5'd9; second_data = 64'h5555_6666_7777_8888;
`else
    first_ready = 2'b10; first_rd = 5'd9; first_data = 64'h5555_6666_7777_8888;
    second_ready = 2'b01; second_rd = 5'd7; second_data = 64'h1111_2222_3333_4444;
`endif
    pulse_reset();
    valid = 2'b11;
    rd    = {5'd9, 5'd7};
    data  = {64'h5555_6666_7777_8888, 64'h1111_2222_3333_4444};
    #1;
    total++; if (ready !== first_ready) begin bad++; $display("FAIL conf_ready1 got=%b want=%b", ready, first_ready); end
    step();
    valid = second_ready;
    #1;
    total++; if (ready !== second_ready) begin bad++; $display("FAIL conf_ready2 got=%b want=%b", ready, second_ready); end
    total++; if (we !== 1'b1 || wrd !== first_rd || wdata !== first_data) begin
      bad++; $display("FAIL conf_write1 got=%b/%0d/%h want=1/%0d/%h", we, wrd, wdata, first_rd, first_data);
    end
    step();
    valid = 2'b00;
    total++; if (we !== 1'b1 || wrd !== second_rd || wdata !== second_data) begin
      bad++; $display("FAIL conf_write2 got=%b/%0d/%h want=1/%0d/%h", we, wrd, wdata, second_rd, second_data);
    end
    total++; if (cnt !== 4'd1) begin bad++; $display("FAIL conf_cnt got=%0d want=1", cnt); end
    step();
    total++; if (we !== 1'b0) begin bad++; $display("FAIL conf_we_drop got=%b want=0", we); end
    // Next conflict: round-robin favours the LSU after an ALU win; fixed is LSU anyway.
    valid = 2'b11;
    #1;
    total++; if (ready !== 2'b10) begin bad++; $display("FAIL conf_next_ready got=%b want=10", ready); end
    step();
    valid = 2'b00;
    total++; if (we !== 1'b1 || wrd !== 5'd9) begin bad++; $display("FAIL conf_next_write got=%b/%0d want=1/9", we, wrd); end
    total++; if (cnt !== 4'd2) begin bad++; $display("FAIL conf_next_cnt got=%0d want=2", cnt); end
    step();
  endtask

  task automatic test_saturation();
    pulse_reset();
    valid = 2'b11;
    rd    = {5'd12, 5'd11};
    data  = {64'hC0C0, 64'hB0B0};
    for (int i = 0; i < 10; i++) step();
    total++; if (cnt !== 4'd10) begin bad++; $display("FAIL sat_cnt10 got=%0d want=10", cnt); end
    for (int i = 0; i < 10; i++) step();
    total++; if (cnt !== 4'd15) begin bad++; $display("FAIL sat_cnt15 got=%0d want=15", cnt); end
    total++; if (we !== 1'b1) begin bad++; $display("FAIL sat_we got=%b want=1", we); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (cnt !== 4'd0) begin bad++; $display("FAIL sat_async_cnt got=%0d want=0", cnt); end
    total++; if (we !== 1'b0) begin bad++; $display("FAIL sat_async_we got=%b want=0", we); end
    total++; if (ready !== 2'b00) begin bad++; $display("FAIL sat_async_ready got=%b want=00", ready); end
    valid = 2'b00;
    step();
    rst_n = 1'b1;
    step();
    total++; if (we !== 1'b0 || wrd !== 5'd0 || wdata !== 64'd0) begin
      bad++; $display("FAIL sat_post_reset got=%b/%0d/%h want=0/0/0", we, wrd, wdata);
    end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_zero_sink();
    test_conflict();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
